// File: rtl/sawtooth_period_meter_pkg.sv
// Shared definitions for the sawtooth period meter.
//   - DefaultPeriodWidth : default width of the period counter / output
//   - meter_state_e      : lock FSM state encoding (Sync=0, First=1, Measure=2, Locked=3)
package sawtooth_period_meter_pkg;

    localparam int unsigned DefaultPeriodWidth = 16;
    localparam int unsigned SampleWidth        = 8;

    typedef enum logic [1:0] {
        StSync    = 2'd0,
        StFirst   = 2'd1,
        StMeasure = 2'd2,
        StLocked  = 2'd3
    } meter_state_e;

endpackage

// File: rtl/sawtooth_wrap_detect.sv
// Wrap detector for an 8-bit sawtooth sample stream.
// Ports:
//   clk       : rising-edge clock
//   reset     : synchronous active-high reset
//   sample_in : current sample, valid every clock
//   wrap      : combinational, high when sample_in < previous sample (strict, unsigned)
//   step      : registered last non-wrap increment (sample_in - previous), modulo 256
module sawtooth_wrap_detect
    import sawtooth_period_meter_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [SampleWidth-1:0] sample_in,
    output logic                   wrap,
    output logic [SampleWidth-1:0] step
);

    logic [SampleWidth-1:0] prev_q;
    logic [SampleWidth-1:0] step_q, step_d;

    // Equal samples are a flat segment, not a wrap.
    assign wrap = (sample_in < prev_q);

    always_comb begin
        step_d = step_q;
        if (!wrap) begin
            step_d = sample_in - prev_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= '0;
            step_q <= '0;
        end else begin
            prev_q <= sample_in;
            step_q <= step_d;
        end
    end

    assign step = step_q;

endmodule

// File: rtl/sawtooth_period_meter.sv
// Sawtooth period meter: measures wrap-to-wrap period and per-clock step of a
// sawtooth stream and reports lock once consecutive periods agree within TOL.
// Ports:
//   clk          : rising-edge clock
//   reset        : synchronous active-high reset
//   sample_in    : 8-bit unsigned sawtooth sample, one per clock
//   period       : last measured period in clocks
//   period_valid : one-cycle pulse when period updates
//   step         : last non-wrap increment, modulo 256
//   locked       : high while the FSM is in the locked state
module sawtooth_period_meter
    import sawtooth_period_meter_pkg::*;
#(
    parameter int unsigned PERIOD_WIDTH = DefaultPeriodWidth,
    parameter int unsigned TOL          = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SampleWidth-1:0]  sample_in,
    output logic [PERIOD_WIDTH-1:0] period,
    output logic                    period_valid,
    output logic [SampleWidth-1:0]  step,
    output logic                    locked
);

    localparam logic [PERIOD_WIDTH-1:0] CntMax = '1;
    localparam logic [PERIOD_WIDTH-1:0] CntOne = PERIOD_WIDTH'(1);
    localparam logic [PERIOD_WIDTH:0]   TolW   = (PERIOD_WIDTH + 1)'(TOL);

    logic wrap;

    meter_state_e            state_q, state_d;
    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic                    period_valid_q, period_valid_d;

    logic                    cnt_sat;
    logic [PERIOD_WIDTH-1:0] meas;
    logic signed [PERIOD_WIDTH:0] diff;
    logic [PERIOD_WIDTH:0]   abs_diff;
    logic                    match;

    sawtooth_wrap_detect u_wrap_detect (
        .clk       (clk),
        .reset     (reset),
        .sample_in (sample_in),
        .wrap      (wrap),
        .step      (step)
    );

    assign cnt_sat = (cnt_q == CntMax);

    // A wrap on a saturated count still reports, clamped to all-ones.
    assign meas = cnt_sat ? CntMax : (cnt_q + CntOne);

    // One extra bit so the subtraction of two unsigned periods cannot wrap.
    assign diff     = $signed({1'b0, meas}) - $signed({1'b0, period_q});
    assign abs_diff = diff[PERIOD_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
    assign match    = (abs_diff <= TolW);

    always_comb begin
        cnt_d = cnt_q;
        if (wrap) begin
            cnt_d = '0;
        end else if (!cnt_sat) begin
            cnt_d = cnt_q + CntOne;
        end
    end

    always_comb begin
        state_d        = state_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        if (wrap) begin
            unique case (state_q)
                StSync: begin
                    state_d = StFirst;
                end
                StFirst: begin
                    period_d       = meas;
                    period_valid_d = 1'b1;
                    state_d        = StMeasure;
                end
                StMeasure: begin
                    period_d       = meas;
                    period_valid_d = 1'b1;
                    if (match) begin
                        state_d = StLocked;
                    end
                end
                StLocked: begin
                    period_d       = meas;
                    period_valid_d = 1'b1;
                    if (!match) begin
                        state_d = StMeasure;
                    end
                end
                default: begin
                    state_d = StSync;
                end
            endcase
        end else if (cnt_sat && (state_q != StSync)) begin
            // Timeout: no wrap for a full counter span. Period holds, no pulse.
            state_d = StSync;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StSync;
            cnt_q          <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign locked       = (state_q == StLocked);

endmodule

// File: tb/tb_sawtooth_period_meter.sv
// Self-checking bench for sawtooth_period_meter. Three instances share one
// stimulus stream: default (W=16, TOL=1), zero tolerance (W=16, TOL=0) and a
// narrow counter (W=4, TOL=1) to reach the timeout quickly.
module tb_sawtooth_period_meter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] sample_in;

    logic [15:0] period0, period1;
    logic [3:0]  period2;
    logic        pv0, pv1, pv2;
    logic [7:0]  step0, step1, step2;
    logic        locked0, locked1, locked2;

    sawtooth_period_meter #(.PERIOD_WIDTH(16), .TOL(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .period       (period0),
        .period_valid (pv0),
        .step         (step0),
        .locked       (locked0)
    );

    sawtooth_period_meter #(.PERIOD_WIDTH(16), .TOL(0)) dut_tol0 (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .period       (period1),
        .period_valid (pv1),
        .step         (step1),
        .locked       (locked1)
    );

    sawtooth_period_meter #(.PERIOD_WIDTH(4), .TOL(1)) dut_w4 (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .period       (period2),
        .period_valid (pv2),
        .step         (step2),
        .locked       (locked2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: elapsed time since the last wrap is an unbounded
    // integer; the reported period is that time clamped to the counter range.
    localparam int MSync = 0, MFirst = 1, MMeasure = 2, MLocked = 3;
    int m_w[3]   = '{16, 16, 4};
    int m_tol[3] = '{1, 0, 1};
    int m_prev[3], m_step[3], m_age[3], m_period[3], m_st[3];
    bit m_pv[3];

    task automatic model_step(input int i, input int s, input bit r);
        int  mx, meas;
        bit  wrap, match;
        mx      = (1 << m_w[i]) - 1;
        m_pv[i] = 1'b0;
        if (r) begin
            m_prev[i] = 0; m_step[i] = 0; m_age[i] = 0; m_period[i] = 0; m_st[i] = MSync;
        end else begin
            wrap = (s < m_prev[i]);
            if (wrap) begin
                meas  = (m_age[i] + 1 > mx) ? mx : m_age[i] + 1;
                match = (meas - m_period[i] <= m_tol[i]) && (m_period[i] - meas <= m_tol[i]);
                if (m_st[i] == MSync) begin
                    m_st[i] = MFirst;
                end else begin
                    if (m_st[i] == MFirst) m_st[i] = MMeasure;
                    else if (m_st[i] == MMeasure && match) m_st[i] = MLocked;
                    else if (m_st[i] == MLocked && !match) m_st[i] = MMeasure;
                    m_period[i] = meas;
                    m_pv[i]     = 1'b1;
                end
                m_age[i] = 0;
            end else begin
                m_step[i] = (s - m_prev[i]) & 255;
                if (m_st[i] != MSync && m_age[i] >= mx) m_st[i] = MSync;
                if (m_age[i] < 1000000) m_age[i]++;
            end
            m_prev[i] = s;
        end
    endtask

    task automatic tick(input int s, input bit r);
        @(negedge clk);
        sample_in = s[7:0];
        reset     = r;
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i, s, r);
        #1;
        check_eq("period0", period0, m_period[0]);
        check_eq("pvalid0", pv0, m_pv[0]);
        check_eq("step0", step0, m_step[0]);
        check_eq("locked0", locked0, m_st[0] == MLocked);
        check_eq("period1", period1, m_period[1]);
        check_eq("pvalid1", pv1, m_pv[1]);
        check_eq("step1", step1, m_step[1]);
        check_eq("locked1", locked1, m_st[1] == MLocked);
        check_eq("period2", period2, m_period[2]);
        check_eq("pvalid2", pv2, m_pv[2]);
        check_eq("step2", step2, m_step[2]);
        check_eq("locked2", locked2, m_st[2] == MLocked);
    endtask

    task automatic ramp(input int stp, input int first, input int n);
        for (int k = first; k < n; k++) tick((k * stp) & 255, 1'b0);
    endtask

    initial begin
        int stp, p, reps;
        reset     = 1'b1;
        sample_in = 8'h00;

        tick(0, 1'b1);
        tick(0, 1'b1);
        check_eq("rst_period", period0, 0);
        check_eq("rst_pvalid", pv0, 0);
        check_eq("rst_step", step0, 0);
        check_eq("rst_locked", locked0, 0);

        // Step-32 sawtooth, period 8.
        for (int j = 0; j < 5; j++) ramp(32, 0, 8);
        check_eq("p8_locked", locked0, 1);
        check_eq("p8_period", period0, 8);
        check_eq("p8_step", step0, 32);

        // Switch to step 16: first 16-period report unlocks, the next relocks.
        ramp(16, 0, 16);
        tick(0, 1'b0);
        check_eq("p16_unlock", locked0, 0);
        check_eq("p16_period", period0, 16);
        ramp(16, 1, 16);
        tick(0, 1'b0);
        check_eq("p16_relock", locked0, 1);
        ramp(16, 1, 16);

        // Jitter 8/9: TOL=1 locks, TOL=0 never does.
        for (int j = 0; j < 4; j++) begin
            ramp(20, 0, 8);
            ramp(20, 0, 9);
        end
        check_eq("jit_tol1", locked0, 1);
        check_eq("jit_tol0", locked1, 0);
        check_eq("jit_w4", locked2, 1);

        // Constant input: narrow counter times out, period holds.
        for (int j = 0; j < 40; j++) tick(8'h80, 1'b0);
        check_eq("to_locked", locked2, 0);
        check_eq("to_period", period2, 9);
        check_eq("to_step", step2, 0);
        check_eq("to_wide_locked", locked0, 1);

        // Reset mid-period while locked.
        for (int j = 0; j < 4; j++) ramp(32, 0, 8);
        ramp(32, 0, 3);
        tick(96, 1'b1);
        check_eq("mid_rst_period", period0, 0);
        check_eq("mid_rst_locked", locked0, 0);
        check_eq("mid_rst_step", step0, 0);
        ramp(32, 4, 8);
        for (int j = 0; j < 3; j++) ramp(32, 0, 8);

        // Edge compares.
        tick(0, 1'b0);
        tick(5, 1'b0); tick(5, 1'b0); tick(5, 1'b0); tick(4, 1'b0);
        tick(255, 1'b0); tick(0, 1'b0);
        tick(255, 1'b0);
        check_eq("edge_step255", step0, 255);

        // Randomized bursts: repeated periods with +/-1 jitter, noise, resets.
        for (int b = 0; b < 120; b++) begin
            stp  = $urandom_range(1, 30);
            p    = $urandom_range(2, 20);
            reps = $urandom_range(1, 4);
            for (int j = 0; j < reps; j++) ramp(stp, 0, p + $urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) tick($urandom_range(0, 255), 1'b0);
            if ($urandom_range(0, 19) == 0) tick($urandom_range(0, 255), 1'b1);
            if ($urandom_range(0, 14) == 0) begin
                stp = $urandom_range(0, 255);
                for (int j = 0; j < 20; j++) tick(stp, 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sawtooth_period_meter.md
# sawtooth_period_meter

Receive-side companion to the sawtooth generator. It watches an 8-bit sawtooth sample stream, one sample per clock, and detects each wrap (a falling discontinuity). It measures the period in clock cycles and the per-clock step size, and asserts `locked` once consecutive periods agree. It sits after the generator in the audio path and is used for self-check and frequency readback.

## Interface
Parameters:
- `PERIOD_WIDTH`, default 16: width of the period counter and output.
- `TOL`, default 1: maximum absolute period difference, in clocks, that still counts as a match.

Ports:
- `clk`, input, 1: single clock. All logic is rising-edge.
- `reset`, input, 1: synchronous, active-high reset.
- `sample_in`, input, 8: sawtooth sample, unsigned, valid every clock.
- `period`, output, `PERIOD_WIDTH`: last measured wrap-to-wrap period in clocks.
- `period_valid`, output, 1: one-cycle pulse when `period` updates.
- `step`, output, 8: last non-wrap increment, `sample_in - prev`, modulo 256.
- `locked`, output, 1: high while in state LOCKED.

## Operation
- `prev_q` registers `sample_in` every cycle.
- `wrap` is combinational: `sample_in < prev_q`, unsigned and strict. Equal samples are not a wrap.
- On non-wrap cycles, `step` is updated to `sample_in - prev_q`, modulo 256. It holds its value on wrap cycles. A constant input therefore gives `step` = 0.
- `cnt_q` counts clocks since the last wrap:
  - cleared to 0 on a wrap cycle;
  - otherwise incremented;
  - saturates at all-ones.
- On a wrap, the measured period is `cnt_q + 1`. A wrap every N cycles gives period N.
- FSM states: SYNC, FIRST, MEASURE, LOCKED.
  - SYNC: on wrap, go to FIRST. No period is reported.
  - FIRST: on wrap, report the period and go to MEASURE.
  - MEASURE: on wrap, report the period. If |new − `period`| ≤ `TOL`, go to LOCKED; otherwise stay.
  - LOCKED: on wrap, report the period. On a mismatch, go to MEASURE.
  - Timeout, from any state except SYNC: `cnt_q` reaches all-ones. Go to SYNC and clear `locked`. `period` holds its value and no pulse is issued.
- Width rule: the comparison uses `PERIOD_WIDTH+1`-bit signed difference. No wrap in the subtraction.

## Timing
- Reset values: `period` = 0, `period_valid` = 0, `step` = 0, `locked` = 0, `prev_q` = 0, `cnt_q` = 0, state = SYNC.
- Latency:
  - `period`, `period_valid` and state update on the clock edge that ends the wrap cycle, i.e. they are visible 1 cycle after the low sample is presented.
  - `step` also has a 1-cycle latency.
- `locked` is registered with the state. It rises on the same edge as the `period_valid` pulse that completes the match.
- Simultaneous wrap and saturation: the wrap wins. The period is reported as all-ones, and match logic applies normally.
- Reset asserted mid-period: all registers take their reset values on that edge. The next sample is compared against `prev_q` = 0, so it cannot wrap.
- The first sample after reset never produces a wrap.

## Structure
- Shared include `sound_defs.vh` holds:
  - state encodings `ST_SYNC`=0, `ST_FIRST`=1, `ST_MEASURE`=2, `ST_LOCKED`=3;
  - default `PERIOD_WIDTH`.
- One sub-module is natural: `sawtooth_wrap_detect`. It contains `prev_q`, the `wrap` compare and the `step` register, and outputs `wrap` and `step`.
- The counter, FSM and match logic live in the top module.

## Test plan
- Generator with `frequency_control`=32, 8 samples/cycle (0,32,…,224,0,…):
  - first `period_valid` at the 2nd wrap, `period`=8;
  - `step`=32;
  - `locked`=1 on the 3rd wrap and stays high.
- Lock, then switch the stream to step 16 (period 16): the first 16-period report drops `locked` (MEASURE), and the next one relocks with `period`=16.
- Jitter within tolerance: alternate periods 8,9,8,9 with `TOL`=1 → `locked` stays 1. With `TOL`=0 → `locked` stays 0.
- Constant input 8'h80 with `PERIOD_WIDTH`=4, starting locked: timeout after the counter saturates → state SYNC, `locked`=0, `period` unchanged, no pulse, `step`=0.
- Reset pulse mid-period while locked: all outputs return to 0 the next cycle. The first `period_valid` after release occurs only at the 2nd subsequent wrap.
- Edge compare: sequence 5,5,5,4 → a single wrap on the sample 4. Sequence 255→0 counts as a wrap. Sequence 0→255 gives `step`=255 with no wrap.
